btb_update_ctrl: RTL and testbench



---
 rtl/btb_update_ctrl_if.sv | 26 ++
 rtl/btb_update_ctrl.sv | 151 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_ctrl_if.sv
// BTB-side port of the update controller: training updates with a valid/ready
// handshake, plus the invalidate strobe the flush walk uses.
interface btb_update_ctrl_if #(
  parameter int BTB_IDX_BITS = 5
);
  logic                    upd_valid;
  logic                    upd_ready;
  logic [31:0]             upd_pc;
  logic [31:0]             upd_target;
  logic                    upd_is_jal;
  logic                    upd_taken;
  logic                    inv_valid;
  logic [BTB_IDX_BITS-1:0] inv_index;

  modport master (
    output upd_valid, upd_pc, upd_target, upd_is_jal, upd_taken,
    output inv_valid, inv_index,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_pc, upd_target, upd_is_jal, upd_taken,
    input  inv_valid, inv_index,
    output upd_ready
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// Queues up to two branch/jal commits per cycle and drains them in order onto the
// BTB's single write port; flush drains the queue then invalidates every BTB index.
module btb_update_ctrl #(
  parameter int QUEUE_DEPTH  = 4,
  parameter int BTB_DEPTH    = 32,
  parameter int BTB_IDX_BITS = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               c0_valid,
  input  logic                               c1_valid,
  input  logic [31:0]                        c0_pc,
  input  logic [31:0]                        c1_pc,
  input  logic [31:0]                        c0_target,
  input  logic [31:0]                        c1_target,
  input  logic                               c0_is_branch,
  input  logic                               c1_is_branch,
  input  logic                               c0_is_jal,
  input  logic                               c1_is_jal,
  input  logic                               c0_taken,
  input  logic                               c1_taken,
  output logic                               commit_ready,
  input  logic                               flush_req,
  output logic                               flush_busy,
  btb_update_ctrl_if.master                  btb,
  output logic [$clog2(QUEUE_DEPTH):0]       queue_count,
  output logic                               overflow_err
);

  localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WALK  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        is_jal;
    logic        taken;
  } entry_t;

  state_t                  state, state_next;
  logic [BTB_IDX_BITS-1:0] inv_index, inv_index_next;
  logic [PTR_BITS-1:0]     head, tail, slot1;
  logic [CNT_BITS-1:0]     count, enq_cnt;
  entry_t                  queue [QUEUE_DEPTH];
  entry_t                  lane0_entry, lane1_entry, head_entry;
  logic                    enq0, enq1, pop, upd_valid;

  // jal is always taken, so the lane's taken bit is only meaningful for branches
  always_comb begin
    lane0_entry.pc     = c0_pc;
    lane0_entry.target = c0_target;
    lane0_entry.is_jal = c0_is_jal;
    lane0_entry.taken  = c0_is_jal | c0_taken;
    lane1_entry.pc     = c1_pc;
    lane1_entry.target = c1_target;
    lane1_entry.is_jal = c1_is_jal;
    lane1_entry.taken  = c1_is_jal | c1_taken;
  end

  // Ready looks only at registered state so it never depends on this cycle's pop
  assign commit_ready = (state == IDLE) && (count <= CNT_BITS'(QUEUE_DEPTH - 2));

  assign enq0    = commit_ready && c0_valid && (c0_is_branch || c0_is_jal);
  assign enq1    = commit_ready && c1_valid && (c1_is_branch || c1_is_jal);
  assign enq_cnt = CNT_BITS'(enq0) + CNT_BITS'(enq1);
  assign slot1   = tail + PTR_BITS'(enq0);

  assign upd_valid  = (count != '0) && (state != WALK);
  assign pop        = upd_valid && btb.upd_ready;
  assign head_entry = queue[head];

  always_ff @(posedge clk) begin
    if (enq0) queue[tail]  <= lane0_entry;
    if (enq1) queue[slot1] <= lane1_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_BITS'(pop);
      tail  <= tail + PTR_BITS'(enq_cnt);
      count <= count + enq_cnt - CNT_BITS'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (!commit_ready && (c0_valid || c1_valid)) begin
      overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      inv_index <= '0;
    end else begin
      state     <= state_next;
      inv_index <= inv_index_next;
    end
  end

  always_comb begin
    state_next     = state;
    inv_index_next = inv_index;
    unique case (state)
      IDLE: begin
        if (flush_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (count == '0) begin
          state_next     = WALK;
          inv_index_next = '0;
        end
      end
      WALK: begin
        if (inv_index == BTB_IDX_BITS'(BTB_DEPTH - 1)) begin
          state_next     = IDLE;
          inv_index_next = '0;
        end else begin
          inv_index_next = inv_index + 1'b1;
        end
      end
      default: begin
        state_next     = IDLE;
        inv_index_next = '0;
      end
    endcase
  end

  assign flush_busy     = (state != IDLE);
  assign queue_count    = count;
  assign btb.upd_valid  = upd_valid;
  assign btb.upd_pc     = head_entry.pc;
  assign btb.upd_target = head_entry.target;
  assign btb.upd_is_jal = head_entry.is_jal;
  assign btb.upd_taken  = head_entry.taken;
  assign btb.inv_valid  = (state == WALK);
  assign btb.inv_index  = inv_index;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: commit/drain ordering, backpressure, wrap,
// flush walk and mid-walk reset, with hand-computed expectations.
module tb_btb_update_ctrl;

  localparam int QUEUE_DEPTH  = 4;
  localparam int BTB_DEPTH    = 32;
  localparam int BTB_IDX_BITS = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c0_valid, c1_valid;
  logic [31:0] c0_pc, c1_pc, c0_target, c1_target;
  logic        c0_is_branch, c1_is_branch, c0_is_jal, c1_is_jal, c0_taken, c1_taken;
  logic        commit_ready, flush_req, flush_busy, overflow_err;
  logic [$clog2(QUEUE_DEPTH):0] queue_count;

  int total = 0;
  int bad   = 0;

  btb_update_ctrl_if #(.BTB_IDX_BITS(BTB_IDX_BITS)) bif ();

  btb_update_ctrl #(
    .QUEUE_DEPTH (QUEUE_DEPTH),
    .BTB_DEPTH   (BTB_DEPTH),
    .BTB_IDX_BITS(BTB_IDX_BITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c0_valid    (c0_valid),
    .c1_valid    (c1_valid),
    .c0_pc       (c0_pc),
    .c1_pc       (c1_pc),
    .c0_target   (c0_target),
    .c1_target   (c1_target),
    .c0_is_branch(c0_is_branch),
    .c1_is_branch(c1_is_branch),
    .c0_is_jal   (c0_is_jal),
    .c1_is_jal   (c1_is_jal),
    .c0_taken    (c0_taken),
    .c1_taken    (c1_taken),
    .commit_ready(commit_ready),
    .flush_req   (flush_req),
    .flush_busy  (flush_busy),
    .btb         (bif.master),
    .queue_count (queue_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLanes();
    c0_valid = 0; c1_valid = 0;
    c0_pc = '0; c1_pc = '0; c0_target = '0; c1_target = '0;
    c0_is_branch = 0; c1_is_branch = 0; c0_is_jal = 0; c1_is_jal = 0;
    c0_taken = 0; c1_taken = 0;
  endtask

  task automatic applyStimulus(input int lane, input logic [31:0] pc, input logic [31:0] target,
                               input logic is_branch, input logic is_jal, input logic taken);
    if (lane == 0) begin
      c0_valid = 1; c0_pc = pc; c0_target = target;
      c0_is_branch = is_branch; c0_is_jal = is_jal; c0_taken = taken;
    end else begin
      c1_valid = 1; c1_pc = pc; c1_target = target;
      c1_is_branch = is_branch; c1_is_jal = is_jal; c1_taken = taken;
    end
  endtask

  initial begin
    clearLanes();
    rst_n = 0; flush_req = 0; bif.upd_ready = 0;
    tick(); tick();
    rst_n = 1;

    checkOutput("rst_commit_ready", commit_ready, 1);
    checkOutput("rst_upd_valid",    bif.upd_valid, 0);
    checkOutput("rst_count",        queue_count, 0);
    checkOutput("rst_inv_valid",    bif.inv_valid, 0);
    checkOutput("rst_inv_index",    bif.inv_index, 0);
    checkOutput("rst_flush_busy",   flush_busy, 0);
    checkOutput("rst_overflow",     overflow_err, 0);

    // dual commit with ready held high
    bif.upd_ready = 1;
    applyStimulus(0, 32'h100, 32'h180, 1, 0, 1);
    applyStimulus(1, 32'h104, 32'h200, 0, 1, 0);
    tick();
    clearLanes();
    checkOutput("dual_count2",  queue_count, 2);
    checkOutput("dual_valid0",  bif.upd_valid, 1);
    checkOutput("dual_pc0",     bif.upd_pc, 32'h100);
    checkOutput("dual_tgt0",    bif.upd_target, 32'h180);
    checkOutput("dual_taken0",  bif.upd_taken, 1);
    checkOutput("dual_jal0",    bif.upd_is_jal, 0);
    tick();
    checkOutput("dual_count1",  queue_count, 1);
    checkOutput("dual_pc1",     bif.upd_pc, 32'h104);
    checkOutput("dual_jal1",    bif.upd_is_jal, 1);
    checkOutput("dual_tgt1",    bif.upd_target, 32'h200);
    tick();
    checkOutput("dual_count0",  queue_count, 0);
    checkOutput("dual_valid_e", bif.upd_valid, 0);

    // backpressure until full, then an overflowing lane
    bif.upd_ready = 0;
    applyStimulus(0, 32'h300, 32'h1300, 1, 0, 0);
    applyStimulus(1, 32'h304, 32'h1304, 1, 0, 1);
    tick();
    clearLanes();
    checkOutput("bp_count2", queue_count, 2);
    checkOutput("bp_ready2", commit_ready, 1);
    applyStimulus(0, 32'h308, 32'h1308, 1, 0, 1);
    tick();
    clearLanes();
    checkOutput("bp_count3", queue_count, 3);
    checkOutput("bp_ready3", commit_ready, 0);
    checkOutput("bp_hold_a", bif.upd_pc, 32'h300);
    checkOutput("bp_noovf",  overflow_err, 0);
    applyStimulus(0, 32'h30c, 32'h130c, 1, 0, 1);
    tick();
    clearLanes();
    checkOutput("bp_overflow", overflow_err, 1);
    checkOutput("bp_drop",     queue_count, 3);
    checkOutput("bp_hold_b",   bif.upd_pc, 32'h300);
    checkOutput("bp_valid",    bif.upd_valid, 1);
    bif.upd_ready = 1;
    tick();
    checkOutput("bp_pc1",  bif.upd_pc, 32'h304);
    checkOutput("bp_tk1",  bif.upd_taken, 1);
    tick();
    checkOutput("bp_pc2",  bif.upd_pc, 32'h308);
    tick();
    checkOutput("bp_empty",   queue_count, 0);
    checkOutput("bp_sticky",  overflow_err, 1);

    // a valid lane without branch/jal kind is not queued
    bif.upd_ready = 0;
    applyStimulus(0, 32'h3f0, 32'h0, 0, 0, 1);
    applyStimulus(1, 32'h400, 32'h480, 1, 0, 0);
    tick();
    clearLanes();
    checkOutput("inelig_count", queue_count, 1);
    checkOutput("inelig_pc",    bif.upd_pc, 32'h400);
    bif.upd_ready = 1;
    tick();
    checkOutput("inelig_drain", queue_count, 0);

    // steady 1-in/1-out across several pointer wraps
    applyStimulus(0, 32'h500, 32'h900, 1, 0, 0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 32'h500 + 32'(4 * i), 32'h900, 1, 0, 0);
      tick();
      checkOutput($sformatf("wrap_count%0d", i), queue_count, 1);
      checkOutput($sformatf("wrap_pc%0d", i), bif.upd_pc, 32'h500 + 32'(4 * i));
    end
    clearLanes();
    tick();
    checkOutput("wrap_empty", queue_count, 0);

    // flush with two entries queued
    bif.upd_ready = 0;
    applyStimulus(0, 32'h600, 32'h700, 1, 0, 1);
    applyStimulus(1, 32'h604, 32'h704, 0, 1, 0);
    tick();
    clearLanes();
    checkOutput("fl_count2", queue_count, 2);
    bif.upd_ready = 1;
    flush_req = 1;
    tick();
    flush_req = 0;
    checkOutput("fl_busy_d",  flush_busy, 1);
    checkOutput("fl_ready_d", commit_ready, 0);
    checkOutput("fl_pc_d",    bif.upd_pc, 32'h604);
    checkOutput("fl_inv_d",   bif.inv_valid, 0);
    tick();
    checkOutput("fl_count0",  queue_count, 0);
    checkOutput("fl_busy_d2", flush_busy, 1);
    checkOutput("fl_inv_d2",  bif.inv_valid, 0);
    tick();
    for (int i = 0; i < BTB_DEPTH; i++) begin
      checkOutput($sformatf("walk_inv%0d", i), bif.inv_valid, 1);
      checkOutput($sformatf("walk_idx%0d", i), bif.inv_index, 32'(i));
      checkOutput($sformatf("walk_upd%0d", i), bif.upd_valid, 0);
      flush_req = (i == 5);
      tick();
    end
    flush_req = 0;
    checkOutput("fl_done_inv",   bif.inv_valid, 0);
    checkOutput("fl_done_busy",  flush_busy, 0);
    checkOutput("fl_done_ready", commit_ready, 1);
    tick();
    checkOutput("fl_no_requeue", flush_busy, 0);

    // reset in the middle of the walk
    flush_req = 1;
    tick();
    flush_req = 0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    checkOutput("mid_idx10",  bif.inv_index, 10);
    checkOutput("mid_inv",    bif.inv_valid, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    checkOutput("mrst_inv",      bif.inv_valid, 0);
    checkOutput("mrst_busy",     flush_busy, 0);
    checkOutput("mrst_ready",    commit_ready, 1);
    checkOutput("mrst_idx",      bif.inv_index, 0);
    checkOutput("mrst_overflow", overflow_err, 0);
    checkOutput("mrst_count",    queue_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
